// File: rtl/vx_operand_collector_fwd.sv
// Per-issue-lane operand collector with writeback forwarding.
// Each source operand has its own GPR bank copy with a registered read port.
// Read data is paired with the instruction metadata in a stage-1 register and
// then pushed into a small queue toward dispatch.
// An external (tensor-core) reader borrows the last bank copy through an
// arbiter that limits how long it can starve the instruction stream.
module vx_operand_collector_fwd #(
    parameter int NUM_SRCS    = 3,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int REG_BITS    = 5,
    parameter int WIS_BITS    = 1,
    parameter int META_W      = 96,
    parameter int DEPTH       = 4,
    parameter int BYPASS_EN   = 1,
    parameter int STARVE_MAX  = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [META_W-1:0]                       in_meta,
    input  logic [NUM_SRCS*(WIS_BITS+REG_BITS)-1:0] in_src_addr,
    input  logic                                    wb_valid,
    input  logic [WIS_BITS+REG_BITS-1:0]            wb_addr,
    input  logic [NUM_THREADS-1:0]                  wb_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]             wb_data,
    input  logic                                    ext_req_valid,
    output logic                                    ext_req_ready,
    input  logic [WIS_BITS+REG_BITS-1:0]            ext_req_addr,
    output logic                                    ext_rsp_valid,
    output logic [NUM_THREADS*XLEN-1:0]             ext_rsp_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [META_W-1:0]                       out_meta,
    output logic [NUM_SRCS*NUM_THREADS*XLEN-1:0]    out_data,
    output logic [31:0]                             perf_reads,
    output logic [31:0]                             perf_writes
);

    localparam int ADDRW    = WIS_BITS + REG_BITS;
    localparam int NUM_REGS = int'(32'd1 << ADDRW);
    localparam int TW       = NUM_THREADS * XLEN;
    localparam int DW       = NUM_SRCS * TW;
    localparam int PTRW     = $clog2(DEPTH);
    localparam int CNTW     = $clog2(DEPTH + 32'sd1);
    localparam int OCCW     = CNTW + 32'sd1;
    localparam int STW      = $clog2(STARVE_MAX + 32'sd1);
    localparam int LAST     = NUM_SRCS - 32'sd1;
    localparam bit BYP_EN   = (BYPASS_EN > 32'sd0);

    // Number of set bits in a thread mask.
    function automatic logic [31:0] popcount(input logic [NUM_THREADS-1:0] mask);
        logic [31:0] cnt;
        cnt = 32'd0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            cnt = cnt + {31'd0, mask[i]};
        end
        return cnt;
    endfunction

    logic                  ext_grant_s;
    logic                  in_ready_s;
    logic                  in_fire_s;
    logic                  out_valid_s;
    logic                  out_fire_s;
    logic [OCCW-1:0]       occ_s;
    logic [ADDRW-1:0]      bank_raddr_s [NUM_SRCS];
    logic [DW-1:0]         bank_rd_s;
    logic [DW-1:0]         s1_data_s;

    logic                  s1_valid_r;
    logic [META_W-1:0]     s1_meta_r;
    logic [NUM_SRCS-1:0]   s1_zero_r;
    logic [META_W-1:0]     q_meta_r [DEPTH];
    logic [DW-1:0]         q_data_r [DEPTH];
    logic [PTRW-1:0]       wr_ptr_r;
    logic [PTRW-1:0]       rd_ptr_r;
    logic [CNTW-1:0]       count_r;
    logic [STW-1:0]        starve_cnt_r;
    logic                  ext_rsp_valid_r;
    logic [31:0]           perf_reads_r;
    logic [31:0]           perf_writes_r;

    // Arbitration and credit: the last queue slot is held back for the stage-1 entry.
    always_comb begin
        occ_s       = {1'b0, count_r} + {{CNTW{1'b0}}, s1_valid_r};
        ext_grant_s = !reset && ext_req_valid
                      && !(in_valid && (starve_cnt_r == STW'(STARVE_MAX)));
        in_ready_s  = !reset && (occ_s < OCCW'(DEPTH - 32'sd1)) && !ext_grant_s;
        in_fire_s   = in_valid && in_ready_s;
        out_valid_s = !reset && (count_r != {CNTW{1'b0}});
        out_fire_s  = out_valid_s && out_ready;
    end

    // Bank read addresses: one operand slot per bank, the last bank lent to the external port on a grant.
    always_comb begin
        for (int b = 0; b < NUM_SRCS; b++) begin
            bank_raddr_s[b] = {ADDRW{1'b0}};
        end
        for (int b = 0; b < NUM_SRCS; b++) begin
            if ((b == LAST) && ext_grant_s) begin
                bank_raddr_s[b] = ext_req_addr;
            end else begin
                bank_raddr_s[b] = in_src_addr[b*ADDRW +: ADDRW];
            end
        end
    end

    for (genvar b = 0; b < NUM_SRCS; b++) begin : g_bank
        for (genvar j = 0; j < NUM_THREADS; j++) begin : g_thr
            logic [XLEN-1:0] mem_r [NUM_REGS];
            logic [XLEN-1:0] rd_r;
            logic            fwd_s;

            assign fwd_s = BYP_EN && wb_valid && wb_tmask[j] && (wb_addr == bank_raddr_s[b]);

            // Writeback port: every bank copy takes the same per-thread write.
            always_ff @(posedge clk) begin
                if (wb_valid && wb_tmask[j]) begin
                    mem_r[wb_addr] <= wb_data[j*XLEN +: XLEN];
                end
            end

            // Registered read; a same-cycle write to the same address is forwarded when enabled.
            always_ff @(posedge clk) begin
                if (fwd_s) begin
                    rd_r <= wb_data[j*XLEN +: XLEN];
                end else begin
                    rd_r <= mem_r[bank_raddr_s[b]];
                end
            end

            assign bank_rd_s[(b*NUM_THREADS + j)*XLEN +: XLEN] = rd_r;
        end
    end

    // Stage-1 register: metadata and zero-register flags travel alongside the bank reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= in_fire_s;
        end
        if (in_fire_s) begin
            s1_meta_r <= in_meta;
            for (int s = 0; s < NUM_SRCS; s++) begin
                s1_zero_r[s] <= (in_src_addr[s*ADDRW +: REG_BITS] == {REG_BITS{1'b0}});
            end
        end
    end

    // Stage-1 operand data: the zero register overrides both the bank and forwarded values.
    always_comb begin
        s1_data_s = {DW{1'b0}};
        for (int s = 0; s < NUM_SRCS; s++) begin
            if (s1_zero_r[s]) begin
                s1_data_s[s*TW +: TW] = {TW{1'b0}};
            end else begin
                s1_data_s[s*TW +: TW] = bank_rd_s[s*TW +: TW];
            end
        end
    end

    // Queue storage: stage 1 pushes whenever it holds a valid entry.
    always_ff @(posedge clk) begin
        if (s1_valid_r) begin
            q_meta_r[wr_ptr_r] <= s1_meta_r;
            q_data_r[wr_ptr_r] <= s1_data_s;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTRW{1'b0}};
            rd_ptr_r <= {PTRW{1'b0}};
            count_r  <= {CNTW{1'b0}};
        end else begin
            if (s1_valid_r) begin
                wr_ptr_r <= wr_ptr_r + PTRW'(1);
            end
            if (out_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTRW'(1);
            end
            case ({s1_valid_r, out_fire_s})
                2'b10:   count_r <= count_r + CNTW'(1);
                2'b01:   count_r <= count_r - CNTW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Starvation counter: consecutive external grants while an instruction waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= {STW{1'b0}};
        end else if (!in_valid || in_fire_s) begin
            starve_cnt_r <= {STW{1'b0}};
        end else if (ext_grant_s && (starve_cnt_r != STW'(STARVE_MAX))) begin
            starve_cnt_r <= starve_cnt_r + STW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // External response valid follows its grant by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_rsp_valid_r <= 1'b0;
        end else begin
            ext_rsp_valid_r <= ext_grant_s;
        end
    end

    // Performance counters: thread-register reads and writes, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_reads_r  <= 32'd0;
            perf_writes_r <= 32'd0;
        end else begin
            if (in_fire_s) begin
                perf_reads_r <= perf_reads_r + 32'(NUM_SRCS * NUM_THREADS);
            end else if (ext_grant_s) begin
                perf_reads_r <= perf_reads_r + 32'(NUM_THREADS);
            end else begin
                perf_reads_r <= perf_reads_r;
            end
            if (wb_valid) begin
                perf_writes_r <= perf_writes_r + 32'(NUM_SRCS) * popcount(wb_tmask);
            end else begin
                perf_writes_r <= perf_writes_r;
            end
        end
    end

    assign in_ready      = in_ready_s;
    assign ext_req_ready = ext_grant_s;
    assign ext_rsp_valid = ext_rsp_valid_r && !reset;
    assign ext_rsp_data  = bank_rd_s[LAST*TW +: TW];
    assign out_valid     = out_valid_s;
    assign out_meta      = q_meta_r[rd_ptr_r];
    assign out_data      = q_data_r[rd_ptr_r];
    assign perf_reads    = perf_reads_r;
    assign perf_writes   = perf_writes_r;

endmodule

// File: tb/tb_vx_operand_collector_fwd.sv
// Scoreboard bench for vx_operand_collector_fwd: one instance with forwarding,
// one without, driven by the same stimulus.
module tb_vx_operand_collector_fwd;

    localparam int NS       = 3;
    localparam int NT       = 4;
    localparam int XLEN     = 32;
    localparam int REG_BITS = 5;
    localparam int ADDRW    = 6;
    localparam int META_W   = 96;
    localparam int NUM_REGS = 64;
    localparam int TW       = NT * XLEN;
    localparam int DW       = NS * TW;
    localparam int CW       = 384;

    logic clk = 1'b0;
    logic reset;
    logic in_valid, in_ready, in_ready_nb;
    logic [META_W-1:0] in_meta;
    logic [NS*ADDRW-1:0] in_src_addr;
    logic wb_valid;
    logic [ADDRW-1:0] wb_addr;
    logic [NT-1:0] wb_tmask;
    logic [TW-1:0] wb_data;
    logic ext_req_valid, ext_req_ready, ext_req_ready_nb;
    logic [ADDRW-1:0] ext_req_addr;
    logic ext_rsp_valid, ext_rsp_valid_nb;
    logic [TW-1:0] ext_rsp_data, ext_rsp_data_nb;
    logic out_valid, out_valid_nb, out_ready;
    logic [META_W-1:0] out_meta, out_meta_nb;
    logic [DW-1:0] out_data, out_data_nb;
    logic [31:0] perf_reads, perf_writes, perf_reads_nb, perf_writes_nb;

    always #5 clk = ~clk;

    vx_operand_collector_fwd dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_meta(in_meta), .in_src_addr(in_src_addr), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_tmask(wb_tmask), .wb_data(wb_data),
        .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
        .ext_req_addr(ext_req_addr), .ext_rsp_valid(ext_rsp_valid),
        .ext_rsp_data(ext_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_meta(out_meta), .out_data(out_data), .perf_reads(perf_reads),
        .perf_writes(perf_writes)
    );

    vx_operand_collector_fwd #(.BYPASS_EN(0)) dut_nb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nb),
        .in_meta(in_meta), .in_src_addr(in_src_addr), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_tmask(wb_tmask), .wb_data(wb_data),
        .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready_nb),
        .ext_req_addr(ext_req_addr), .ext_rsp_valid(ext_rsp_valid_nb),
        .ext_rsp_data(ext_rsp_data_nb), .out_valid(out_valid_nb), .out_ready(out_ready),
        .out_meta(out_meta_nb), .out_data(out_data_nb), .perf_reads(perf_reads_nb),
        .perf_writes(perf_writes_nb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // reference GPR and scoreboard queues
    logic [XLEN-1:0] gpr [NUM_REGS][NT];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_nb_q[$];
    logic [META_W-1:0] exp_meta_q[$];
    logic [TW-1:0] ext_q[$];
    logic [TW-1:0] ext_nb_q[$];
    logic [31:0] m_reads = 32'd0;
    logic [31:0] m_writes = 32'd0;
    bit sb_en = 1'b0;
    bit log_en = 1'b0;
    int ev_log[$];

    function automatic logic [TW-1:0] model_read(input logic [ADDRW-1:0] a, input bit byp, input bit zero_en);
        logic [TW-1:0] r;
        r = '0;
        for (int j = 0; j < NT; j++) begin
            r[j*XLEN +: XLEN] = gpr[a][j];
            if (byp && wb_valid && wb_addr == a && wb_tmask[j])
                r[j*XLEN +: XLEN] = wb_data[j*XLEN +: XLEN];
        end
        if (zero_en && a[REG_BITS-1:0] == 5'd0) r = '0;
        return r;
    endfunction

    // scoreboard: compare responses, then record this cycle's accepts/grants/writes
    always @(negedge clk) begin
        logic [DW-1:0] e, enb;
        logic [TW-1:0] x;
        if (sb_en) begin
            check_eq("perf_reads", perf_reads, m_reads);
            check_eq("perf_writes", perf_writes, m_writes);
            check_eq("perf_reads_nb", perf_reads_nb, m_reads);
            if (reset) begin
                check_eq("rst_out_valid", out_valid, 1'b0);
                check_eq("rst_in_ready", in_ready, 1'b0);
                check_eq("rst_ext_req_ready", ext_req_ready, 1'b0);
                check_eq("rst_ext_rsp_valid", ext_rsp_valid, 1'b0);
                exp_q.delete(); exp_nb_q.delete(); exp_meta_q.delete();
                ext_q.delete(); ext_nb_q.delete();
                m_reads = 32'd0;
                m_writes = 32'd0;
            end else begin
                if (ext_q.size() > 0) begin
                    check_eq("ext_rsp_valid", ext_rsp_valid, 1'b1);
                    x = ext_q.pop_front();
                    check_eq("ext_rsp_data", ext_rsp_data, x);
                    x = ext_nb_q.pop_front();
                    check_eq("ext_rsp_data_nb", ext_rsp_data_nb, x);
                end else if (ext_rsp_valid) begin
                    check_eq("ext_rsp_spurious", ext_rsp_valid, 1'b0);
                end
                if (out_valid && exp_q.size() == 0) begin
                    check_eq("out_stale", out_valid, 1'b0);
                end else if (out_valid && out_ready) begin
                    e = exp_q.pop_front();
                    enb = exp_nb_q.pop_front();
                    check_eq("out_data", out_data, e);
                    check_eq("out_data_nb", out_data_nb, enb);
                    check_eq("out_meta", out_meta, exp_meta_q.pop_front());
                end
                if (in_valid && in_ready) begin
                    for (int s = 0; s < NS; s++) begin
                        e[s*TW +: TW] = model_read(in_src_addr[s*ADDRW +: ADDRW], 1'b1, 1'b1);
                        enb[s*TW +: TW] = model_read(in_src_addr[s*ADDRW +: ADDRW], 1'b0, 1'b1);
                    end
                    exp_q.push_back(e);
                    exp_nb_q.push_back(enb);
                    exp_meta_q.push_back(in_meta);
                    m_reads = m_reads + 32'd12;
                end
                if (ext_req_ready) begin
                    ext_q.push_back(model_read(ext_req_addr, 1'b1, 1'b0));
                    ext_nb_q.push_back(model_read(ext_req_addr, 1'b0, 1'b0));
                    m_reads = m_reads + 32'd4;
                end
                if (wb_valid) m_writes = m_writes + 32'd3 * 32'($countones(wb_tmask));
                if (log_en) ev_log.push_back(ext_req_ready ? 1 : ((in_valid && in_ready) ? 2 : 0));
            end
            if (wb_valid) begin
                for (int j = 0; j < NT; j++)
                    if (wb_tmask[j]) gpr[wb_addr][j] = wb_data[j*XLEN +: XLEN];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [NS*ADDRW-1:0] a, input logic [META_W-1:0] m);
        int n;
        n = 0;
        in_valid = 1'b1; in_src_addr = a; in_meta = m;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("issue_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic stream(input int cycles, inout int seq, output int acc);
        bit took;
        acc = 0;
        in_valid = 1'b1;
        in_src_addr = {6'(seq + 2), 6'(seq + 1), 6'(seq)};
        in_meta = 96'(seq);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            tick();
            if (took) begin
                seq++;
                in_src_addr = {6'(seq + 2), 6'(seq + 1), 6'(seq)};
                in_meta = 96'(seq);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int acc, seq;
        logic [DW-1:0] v;
        reset = 1'b1; in_valid = 1'b0; in_meta = '0; in_src_addr = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_tmask = '0; wb_data = '0;
        ext_req_valid = 1'b0; ext_req_addr = '0; out_ready = 1'b1;
        tick();
        sb_en = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // fill every register with a known pattern
        for (int a = 0; a < NUM_REGS; a++) begin
            wb_valid = 1'b1; wb_addr = 6'(a); wb_tmask = 4'hF;
            for (int j = 0; j < NT; j++) wb_data[j*XLEN +: XLEN] = 32'h1000_0000 + 32'(a * 256 + j);
            tick();
        end
        wb_valid = 1'b0;

        // basic read, zero register, two-cycle latency
        wb_valid = 1'b1; wb_addr = 6'd5; wb_tmask = 4'hF;
        wb_data = {32'h44, 32'h33, 32'h22, 32'h11};
        tick();
        wb_valid = 1'b0;
        tick();
        issue({6'd5, 6'd0, 6'd5}, 96'h1);
        @(negedge clk);
        check_eq("t1_lat_t1", out_valid, 1'b0);
        @(negedge clk);
        check_eq("t1_lat_t2", out_valid, 1'b1);
        check_eq("t1_data", out_data,
                 {32'h44, 32'h33, 32'h22, 32'h11, 128'h0, 32'h44, 32'h33, 32'h22, 32'h11});
        tick();

        // same-cycle writeback forwarding vs. no forwarding
        wb_valid = 1'b1; wb_addr = 6'd7; wb_tmask = 4'hF;
        wb_data = {32'h73, 32'h72, 32'h71, 32'h70};
        tick();
        wb_valid = 1'b1; wb_addr = 6'd7; wb_tmask = 4'b0101;
        wb_data = {32'hAB, 32'hAB, 32'hAB, 32'hAB};
        issue({6'd7, 6'd7, 6'd7}, 96'h2);
        wb_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        v = {3{32'h73, 32'hAB, 32'h71, 32'hAB}};
        check_eq("t2_fwd", out_data, v);
        v = {3{32'h73, 32'h72, 32'h71, 32'h70}};
        check_eq("t2_nofwd", out_data_nb, v);
        tick();
        issue({6'd7, 6'd7, 6'd7}, 96'h3);
        repeat (3) tick();

        // back-pressure: three accepts fill the credit, one pop frees one
        out_ready = 1'b0;
        seq = 10;
        stream(8, seq, acc);
        check_eq("t3_accepts", acc, 3);
        @(negedge clk);
        check_eq("t3_ready_low", in_ready, 1'b0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        stream(6, seq, acc);
        check_eq("t3_accepts_after_pop", acc, 1);
        out_ready = 1'b1;
        repeat (8) tick();
        check_eq("t3_drained", exp_q.size(), 0);

        // starvation protection: 8 grants, 1 accept, repeat
        ev_log.delete();
        log_en = 1'b1;
        in_valid = 1'b1; in_src_addr = {6'd3, 6'd2, 6'd1}; in_meta = 96'h44;
        ext_req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            ext_req_addr = 6'(c * 5 + 1);
            tick();
        end
        in_valid = 1'b0; ext_req_valid = 1'b0;
        log_en = 1'b0;
        check_eq("t4_log_len", ev_log.size(), 20);
        for (int i = 0; i < ev_log.size(); i++)
            check_eq($sformatf("t4_event_%0d", i), ev_log[i], ((i % 9) == 8) ? 2 : 1);
        repeat (4) tick();

        // reset with two entries queued
        out_ready = 1'b0;
        issue({6'd9, 6'd8, 6'd7}, 96'h55);
        issue({6'd12, 6'd11, 6'd10}, 96'h56);
        tick();
        @(negedge clk);
        check_eq("t5_pre_valid", out_valid, 1'b1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_ov_a", out_valid, 1'b0);
        tick();
        @(negedge clk);
        check_eq("t5_rst_ov_b", out_valid, 1'b0);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("t5_perf_reads", perf_reads, 32'd0);
        check_eq("t5_perf_writes", perf_writes, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("t5_no_stale", out_valid, 1'b0);
        end
        tick();

        // zero register in wis 1; external port is exempt
        wb_valid = 1'b1; wb_addr = 6'd32; wb_tmask = 4'hF;
        wb_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        tick();
        wb_valid = 1'b0;
        tick();
        issue({6'd32, 6'd5, 6'd32}, 96'h66);
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_valid", out_valid, 1'b1);
        check_eq("t6_data", out_data, {128'h0, 32'h44, 32'h33, 32'h22, 32'h11, 128'h0});
        tick();
        ext_req_valid = 1'b1; ext_req_addr = 6'd32;
        @(negedge clk);
        check_eq("t6_ext_grant", ext_req_ready, 1'b1);
        tick();
        ext_req_valid = 1'b0;
        @(negedge clk);
        check_eq("t6_ext_valid", ext_rsp_valid, 1'b1);
        check_eq("t6_ext_data", ext_rsp_data, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        tick();

        // external read with same-cycle writeback
        ext_req_valid = 1'b1; ext_req_addr = 6'd9;
        wb_valid = 1'b1; wb_addr = 6'd9; wb_tmask = 4'b1000;
        wb_data = {32'hEE, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
        tick();
        ext_req_valid = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        check_eq("t7_ext_fwd", ext_rsp_data, {32'hEE, 32'h1000_0902, 32'h1000_0901, 32'h1000_0900});
        check_eq("t7_ext_nofwd", ext_rsp_data_nb,
                 {32'h1000_0903, 32'h1000_0902, 32'h1000_0901, 32'h1000_0900});
        repeat (4) tick();
        check_eq("sb_empty", exp_q.size() + ext_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
